phase_sequencer: RTL
====================

# phase_sequencer

Control block that sequences the four-word program memory and shares its write port with an external loader. It generates the phase code driving the memory (fetch instruction, fetch data, execute, advance), owns the 2-bit program counter, and arbitrates between running the program and accepting loader writes. Sits between the top-level run/halt controls and the memory/CU pair.

## Interface
Parameters:
- NWORDS, 4, number of memory words; fixed at 4 so the PC is 2 bits.

Ports:
- CLK  in  1  system clock, all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RUN  in  1  level; start program execution from IDLE.
- HALT_REQ  in  1  single-cycle pulse or level; stop at the next ADV boundary.
- LD_REQ  in  1  level; loader requests one memory write; held until LD_GNT.
- LD_ADDR  in  2  loader target word.
- LD_DATA  in  8  loader word, {data nibble, instruction nibble}.
- LD_GNT  out  1  one-cycle pulse; write performed this cycle.
- P  out  3  phase code to memory/CU: 3'b000 FETCH, 3'b001 DATA, 3'b010 EXEC, 3'b011 ADV, 3'b100 idle/load.
- PC  out  2  current program counter.
- WE  out  1  memory write enable.
- WADDR  out  2  memory write address.
- WDATA  out  8  memory write data.
- BUSY  out  1  high in FETCH/DATA/EXEC/ADV.
- WRAP  out  1  one-cycle pulse when PC advances 3 -> 0.

## Operation
- States: IDLE, FETCH, DATA, EXEC, ADV, LOAD. All outputs registered.
- Reset: state IDLE, P=3'b100, PC=0, WE=0, WADDR=0, WDATA=0, LD_GNT=0, BUSY=0, WRAP=0, halt latch cleared. Reset mid-operation aborts immediately; an in-flight LOAD write is dropped.
- IDLE: LD_REQ has priority -> LOAD; else RUN -> FETCH; else stay.
- LOAD (exactly one cycle): WE=1, WADDR=LD_ADDR, WDATA=LD_DATA, LD_GNT=1, P=3'b100; next IDLE. PC unchanged.
- FETCH -> DATA -> EXEC -> ADV, one cycle each, unconditional.
- ADV: PC <= PC+1 modulo 4; WRAP=1 in the cycle after ADV if PC was 3. Next: IDLE if halt latch set or LD_REQ high, else FETCH.
- Halt latch: set by HALT_REQ in any running state (including ADV itself), cleared on entering IDLE. HALT_REQ in IDLE is ignored.
- RUN ignored while running; RUN held high after a halt restarts immediately from IDLE (one IDLE cycle minimum).
- LD_REQ while running never interrupts a cycle; it is serviced after ADV -> IDLE -> LOAD. A pending loader therefore pauses execution; RUN still high resumes after LOAD.
- WE, LD_GNT low in every state except LOAD.

## Timing
- RUN sampled high in IDLE at edge n: P=3'b000, BUSY=1 after edge n.
- One instruction = 4 cycles; PC increments at the edge leaving ADV.
- HALT_REQ sampled at edge n during FETCH..ADV: returns to IDLE at the edge leaving the current ADV; never truncates FETCH..ADV.
- LD_REQ in IDLE at edge n: LOAD cycle after edge n; LD_GNT/WE high for exactly that cycle; back in IDLE after edge n+1. Back-to-back loads: LOAD, IDLE, LOAD (two cycles per write).
- Simultaneous LD_REQ and RUN in IDLE: LOAD first, then FETCH if RUN still high.

## Structure
- Shared package vsmp_pkg: phase constants (PH_FETCH, PH_DATA, PH_EXEC, PH_ADV, PH_IDLE), state enum, word/nibble width constants.
- Single module; the PC is a 2-bit register inside it, no sub-module.

## Test plan
- Reset with RUN=1 held: P=100, PC=0 during reset; after release P cycles 000,001,010,011 and PC 0,1,2,3,0 with WRAP pulsing once per 16 cycles.
- HALT_REQ pulse during DATA with PC=1: completes EXEC, ADV; PC=2, P=100, BUSY=0 the cycle after ADV.
- IDLE, LD_REQ=1, LD_ADDR=2, LD_DATA=8'hA5: one cycle WE=1, WADDR=2, WDATA=A5, LD_GNT=1; PC unchanged.
- Running with LD_REQ raised in FETCH: no write until after ADV; then IDLE, LOAD, IDLE, FETCH resumes at PC+1.
- LD_REQ and RUN both high in IDLE: LOAD precedes FETCH.
- RST asserted mid-LOAD: WE drops asynchronously, no LD_GNT completes, state IDLE, PC=0.

Source files
------------

// File: rtl/vsmp_pkg.sv
// vsmp_pkg: shared definitions for the four-word program memory subsystem.
//   - Memory geometry: 4-bit nibbles, 8-bit words {data, instruction}, 2-bit addresses.
//   - Phase codes sent to the memory/CU pair.
//   - Sequencer state enum and small decode helpers.
`timescale 1ns/1ps
package vsmp_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 2 * NIB_W;
    localparam int ADDR_W = 2;
    localparam int PC_W   = ADDR_W;

    localparam logic [2:0] PH_FETCH = 3'b000;
    localparam logic [2:0] PH_DATA  = 3'b001;
    localparam logic [2:0] PH_EXEC  = 3'b010;
    localparam logic [2:0] PH_ADV   = 3'b011;
    localparam logic [2:0] PH_IDLE  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA,
        ST_EXEC,
        ST_ADV,
        ST_LOAD
    } state_t;

    // Phase code that the memory/CU sees while the sequencer is in state s.
    function automatic logic [2:0] phase_of(input state_t s);
        case (s)
            ST_FETCH: phase_of = PH_FETCH;
            ST_DATA:  phase_of = PH_DATA;
            ST_EXEC:  phase_of = PH_EXEC;
            ST_ADV:   phase_of = PH_ADV;
            default:  phase_of = PH_IDLE;
        endcase
    endfunction

    // True while an instruction cycle is in progress.
    function automatic logic is_running(input state_t s);
        is_running = (s == ST_FETCH) || (s == ST_DATA) ||
                     (s == ST_EXEC)  || (s == ST_ADV);
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// phase_sequencer: sequences the four-word program memory through
// FETCH -> DATA -> EXEC -> ADV, owns the 2-bit program counter and shares the
// memory write port with an external loader. Every output is a flop.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous, active-high reset
//   RUN       in   level, start execution from IDLE
//   HALT_REQ  in   pulse or level, stop at the next ADV boundary
//   LD_REQ    in   loader write request, held until LD_GNT
//   LD_ADDR   in   loader target word
//   LD_DATA   in   loader word {data nibble, instruction nibble}
//   LD_GNT    out  one-cycle pulse, loader write performed this cycle
//   P         out  phase code to memory/CU
//   PC        out  program counter
//   WE        out  memory write enable
//   WADDR     out  memory write address
//   WDATA     out  memory write data
//   BUSY      out  high during FETCH/DATA/EXEC/ADV
//   WRAP      out  one-cycle pulse after the PC advances 3 -> 0
`timescale 1ns/1ps
module phase_sequencer
    import vsmp_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic              HALT_REQ,
    input  logic              LD_REQ,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [WORD_W-1:0] LD_DATA,
    output logic              LD_GNT,
    output logic [2:0]        P,
    output logic [PC_W-1:0]   PC,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [WORD_W-1:0] WDATA,
    output logic              BUSY,
    output logic              WRAP
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                halt_q, halt_d;
    logic [2:0]          p_q, p_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                wrap_q, wrap_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        halt_d  = halt_q;
        we_d    = 1'b0;
        gnt_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wrap_d  = 1'b0;

        // A halt request anywhere in the instruction cycle is remembered until
        // the cycle finishes; in IDLE it is ignored.
        if (is_running(state_q) && HALT_REQ) begin
            halt_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // The loader wins over RUN so a pending write is never starved.
                if (LD_REQ) begin
                    state_d = ST_LOAD;
                    we_d    = 1'b1;
                    gnt_d   = 1'b1;
                    waddr_d = LD_ADDR;
                    wdata_d = LD_DATA;
                end else if (RUN) begin
                    state_d = ST_FETCH;
                end
            end
            ST_LOAD:  state_d = ST_IDLE;
            ST_FETCH: state_d = ST_DATA;
            ST_DATA:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_ADV;
            ST_ADV: begin
                pc_d   = pc_q + 1'b1;
                wrap_d = (pc_q == PC_W'(NWORDS - 1));
                // HALT_REQ seen on this very edge counts as well as the latch;
                // a pending loader also pauses execution here.
                if (halt_q || HALT_REQ || LD_REQ) begin
                    state_d = ST_IDLE;
                    halt_d  = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Phase and busy are decoded from the next state so they appear
        // as flops aligned with the state they describe.
        p_d    = phase_of(state_d);
        busy_d = is_running(state_d);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            p_q     <= PH_IDLE;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            gnt_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            gnt_q   <= gnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wrap_q  <= wrap_d;
        end
    end

    assign P      = p_q;
    assign PC     = pc_q;
    assign BUSY   = busy_q;
    assign WE     = we_q;
    assign LD_GNT = gnt_q;
    assign WADDR  = waddr_q;
    assign WDATA  = wdata_q;
    assign WRAP   = wrap_q;

endmodule
